// File: rtl/posit_encode.sv
// Posit<32,3> encoder: serially builds the regime/exponent/fraction body,
// then applies round-to-nearest-even and the sign.
module posit_encode #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sign_in,
  input  logic         nar_in,
  input  logic [9:0]   scale_in,
  input  logic [63:0]  mant_in,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BODY_W = N - 1;
  localparam int unsigned FRAC_W = 62;
  localparam int unsigned TAIL_W = ES + FRAC_W;
  localparam int unsigned K_W    = 7;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    IDLE, LOAD, REGIME, EXPO, FRAC, ROUND, DONE_ST
  } state_t;

  state_t                 r_state, w_state_nx;
  logic                   r_sign, r_nar, r_zero;
  logic signed [K_W-1:0]  r_k;
  logic [TAIL_W-1:0]      r_tail;
  logic [BODY_W-1:0]      r_body;
  logic [CNT_W-1:0]       r_fill, r_run;
  logic [1:0]             r_ecnt;
  logic                   r_guard, r_sticky;
  logic [N-1:0]           r_result;
  logic                   r_busy, r_done;

  logic                   w_kpos, w_special, w_last;
  logic [CNT_W-1:0]       w_run_init;
  logic [N-1:0]           w_special_val, w_round_val, w_word;
  logic                   w_bit, w_inc;
  logic [TAIL_W-1:0]      w_tail_nx;
  logic [BODY_W-1:0]      w_body_sum, w_body_fin;
  logic                   w_accept, w_load, w_shift, w_round;

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

  // Classification of the latched request and regime run length
  assign w_kpos     = ~r_k[K_W-1];
  assign w_special  = r_nar | r_zero | (r_k >= 7'sd30) | (r_k <= -7'sd31);
  assign w_run_init = w_kpos ? CNT_W'(r_k + 7'sd1) : CNT_W'(-r_k);
  assign w_last     = (r_fill == CNT_W'(BODY_W - 1));

  // Special-case words (NaR and zero are unsigned)
  always_comb begin
    w_special_val = '0;
    if (r_nar)             w_special_val = N'(32'h8000_0000);
    else if (r_zero)       w_special_val = '0;
    else if (r_k >= 7'sd30) w_special_val = r_sign ? N'(32'h8000_0001) : N'(32'h7FFF_FFFF);
    else                   w_special_val = r_sign ? N'(32'hFFFF_FFFF) : N'(32'h0000_0001);
  end

  // Next stream bit and the remaining tail after this cycle's shift
  always_comb begin
    w_bit     = r_tail[TAIL_W-1];
    w_tail_nx = {r_tail[TAIL_W-2:0], 1'b0};
    if (r_state == REGIME) begin
      w_bit     = (r_run != '0) ? w_kpos : ~w_kpos;
      w_tail_nx = r_tail;
    end
  end

  // Round-to-nearest-even, saturating at maxpos and never reaching zero
  assign w_inc       = r_guard & (r_body[0] | r_sticky);
  assign w_body_sum  = (&r_body) ? r_body : r_body + BODY_W'(w_inc);
  assign w_body_fin  = (w_body_sum == '0) ? BODY_W'(1) : w_body_sum;
  assign w_word      = {1'b0, w_body_fin};
  assign w_round_val = r_sign ? ('0 - w_word) : w_word;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = LOAD;
      LOAD:    w_state_nx = w_special ? DONE_ST : REGIME;
      REGIME:  if (w_last) w_state_nx = ROUND;
               else if (r_run == '0) w_state_nx = EXPO;
      EXPO:    if (w_last) w_state_nx = ROUND;
               else if (r_ecnt == 2'd2) w_state_nx = FRAC;
      FRAC:    if (w_last) w_state_nx = ROUND;
      ROUND:   w_state_nx = DONE_ST;
      DONE_ST: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Datapath control decoded from state
  always_comb begin
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_round  = 1'b0;
    case (r_state)
      IDLE:               w_accept = start;
      LOAD:               w_load   = 1'b1;
      REGIME, EXPO, FRAC: w_shift  = 1'b1;
      ROUND:              w_round  = 1'b1;
      default:            ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign   <= 1'b0;
      r_nar    <= 1'b0;
      r_zero   <= 1'b0;
      r_k      <= '0;
      r_tail   <= '0;
      r_body   <= '0;
      r_fill   <= '0;
      r_run    <= '0;
      r_ecnt   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != IDLE);
      r_done <= (r_state == DONE_ST);
      if (w_accept) begin
        r_sign <= sign_in;
        r_nar  <= nar_in;
        r_zero <= (mant_in == 64'd0);
        r_k    <= $signed(scale_in[9:ES]);
        r_tail <= {scale_in[ES-1:0], mant_in[FRAC_W-1:0]};
      end
      if (w_load) begin
        r_body   <= '0;
        r_fill   <= '0;
        r_run    <= w_run_init;
        r_ecnt   <= '0;
        r_guard  <= 1'b0;
        r_sticky <= 1'b0;
        if (w_special) r_result <= w_special_val;
      end
      if (w_shift) begin
        r_body <= {r_body[BODY_W-2:0], w_bit};
        r_fill <= r_fill + CNT_W'(1);
        r_tail <= w_tail_nx;
        if (r_state == REGIME && r_run != '0) r_run <= r_run - CNT_W'(1);
        if (r_state == EXPO) r_ecnt <= r_ecnt + 2'd1;
        if (w_last) begin
          r_guard  <= w_tail_nx[TAIL_W-1];
          r_sticky <= |w_tail_nx[TAIL_W-2:0];
        end
      end
      if (w_round) r_result <= w_round_val;
    end
  end

endmodule

// File: tb/tb_posit_encode.sv
// Directed bench for posit_encode: result words, latency, busy/done, reset abort.
module tb_posit_encode;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_in;
  logic        nar_in;
  logic [9:0]  scale_in;
  logic [63:0] mant_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  posit_encode #(.N(32), .ES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_in(sign_in),
    .nar_in(nar_in), .scale_in(scale_in), .mant_in(mant_in),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request, scramble inputs after acceptance, and check the outcome
  task automatic run(input string tag, input logic s, input logic nar,
                     input logic [9:0] sc, input logic [63:0] m,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic busy_ok;
    @(negedge clk);
    sign_in = s; nar_in = nar; scale_in = sc; mant_in = m; start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    sign_in  = ~s;
    nar_in   = 1'b0;
    scale_in = 10'($urandom);
    mant_in  = {$urandom, $urandom};
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_between"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int n_done;
    reset = 1'b0; start = 1'b0; sign_in = 1'b0; nar_in = 1'b0;
    scale_in = '0; mant_in = '0;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run("one",      1'b0, 1'b0, 10'd0,   64'h4000_0000_0000_0000, 32'h4000_0000, 34);
    run("neg_one",  1'b1, 1'b0, 10'd0,   64'h4000_0000_0000_0000, 32'hC000_0000, 34);
    run("half",     1'b0, 1'b0, 10'h3F8, 64'h4000_0000_0000_0000, 32'h2000_0000, 34);
    run("k1_e1",    1'b0, 1'b0, 10'd9,   64'h6000_0000_0000_0000, 32'h6300_0000, 34);
    run("rnd_up",   1'b0, 1'b0, 10'd0,   64'h4000_0018_0000_0000, 32'h4000_0002, 34);
    run("rnd_even", 1'b0, 1'b0, 10'd0,   64'h4000_0008_0000_0000, 32'h4000_0000, 34);
    run("k29_tie",  1'b0, 1'b0, 10'd236, 64'h4000_0000_0000_0000, 32'h7FFF_FFFE, 34);
    run("k29_up",   1'b0, 1'b0, 10'd237, 64'h4000_0000_0000_0000, 32'h7FFF_FFFF, 34);
    run("km30_up",  1'b0, 1'b0, 10'h317, 64'h4000_0000_0000_0000, 32'h0000_0002, 34);
    run("maxpos",   1'b0, 1'b0, 10'd255, 64'h4000_0000_0000_0000, 32'h7FFF_FFFF, 2);
    run("neg_max",  1'b1, 1'b0, 10'd240, 64'h4000_0000_0000_0000, 32'h8000_0001, 2);
    run("neg_min",  1'b1, 1'b0, 10'h300, 64'h4000_0000_0000_0000, 32'hFFFF_FFFF, 2);
    run("zero",     1'b1, 1'b0, 10'd0,   64'h0,                   32'h0000_0000, 2);
    run("nar",      1'b1, 1'b1, 10'd9,   64'h4000_0000_0000_0000, 32'h8000_0000, 2);

    // Reset ten cycles into a regular request aborts it silently
    @(negedge clk);
    sign_in = 1'b0; nar_in = 1'b0; scale_in = 10'd0;
    mant_in = 64'h4000_0000_0000_0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run("after_rst", 1'b0, 1'b0, 10'd9, 64'h6000_0000_0000_0000, 32'h6300_0000, 34);

    // Start held high: one done per accepted request, none for DONE_ST cycle
    @(negedge clk);
    sign_in = 1'b0; nar_in = 1'b0; scale_in = 10'd0;
    mant_in = 64'h4000_0000_0000_0000; start = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int i = 1; i <= 69; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("held_start_dones", 32'(n_done), 32'd2);
    check("held_start_result", result, 32'h4000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/posit_encode.md
POSIT_ENCODE -- requirements
Module: posit_encode

Interface
REQ-001 SHALL have parameter N, default 32, posit word width; only 32 needs support.
REQ-002 SHALL have parameter ES, default 3, exponent field width; only 3 needs support.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request pulse, accepted only in IDLE.
REQ-006 SHALL have port sign_in  input  1  sign of result (1 = negative).
REQ-007 SHALL have port nar_in  input  1  result is NaR.
REQ-008 SHALL have port scale_in  input  10  two's-complement scale from the adjustment stage: k = scale_in >>> 3 (arithmetic), e = scale_in[2:0].
REQ-009 SHALL have port mant_in  input  64  normalized mantissa: hidden bit at [62], fraction in [61:0].
REQ-010 SHALL have port result  output  32  encoded posit.
REQ-011 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse when result is valid.

Function
REQ-013 States SHALL be IDLE, LOAD, REGIME, EXPO, FRAC, ROUND, DONE_ST.
REQ-014 IDLE: start=1 SHALL latch all inputs and go to LOAD; start outside IDLE SHALL be ignored.
REQ-015 LOAD SHALL classify the request in this priority: nar_in -> 0x80000000; mant_in==0 -> 0x00000000; k>=30 -> maxpos 0x7FFFFFFF before sign; k<=-31 -> minpos 0x00000001 before sign; any of these SHALL go directly to DONE_ST.
REQ-016 Otherwise LOAD SHALL clear a 31-bit body register and fill counter, set run length R = k+1 (k>=0) or -k (k<0), and go to REGIME.
REQ-017 REGIME SHALL shift one bit per cycle into body LSB: R copies of (k>=0), then one terminator bit ~(k>=0); then go to EXPO.
REQ-018 EXPO SHALL shift e[2], e[1], e[0] one per cycle; FRAC SHALL shift mant[61], mant[60], ... one per cycle.
REQ-019 Filling SHALL stop after exactly 31 body bits, whichever field is active; the next stream bit SHALL be guard and the OR of all later stream bits (remaining exponent and fraction bits) SHALL be sticky; then go to ROUND.
REQ-020 Regular path latency: done SHALL rise exactly 34 clock edges after the edge sampling start (LOAD 1, shift 31, ROUND 1, DONE_ST 1).
REQ-021 Special path latency: done SHALL rise exactly 2 edges after the start-sampling edge.
REQ-022 ROUND SHALL apply round-to-nearest-even: increment body iff guard & (body[0] | sticky).
REQ-023 A rounded body of 0x7FFFFFFF SHALL remain at 0x7FFFFFFF; it SHALL never wrap into the sign bit. A body of 0 SHALL become 0x00000001; the block never rounds to zero.
REQ-024 The final word SHALL be {1'b0, body}, replaced by its 32-bit two's complement when sign_in=1. NaR and zero SHALL ignore sign_in.
REQ-025 result SHALL update in the DONE_ST-entry cycle and hold until the next accepted request reaches DONE_ST.
REQ-026 DONE_ST SHALL assert done for one cycle and return to IDLE; a start in that same cycle SHALL be ignored.
REQ-027 Input changes after acceptance SHALL not affect the in-flight result.

Reset
REQ-028 reset=0 SHALL asynchronously force state IDLE, result=0, busy=0, done=0, and clear body, counters, guard and sticky.
REQ-029 Reset mid-operation SHALL abort with no done pulse; the first start after release SHALL be processed normally.

Verification
REQ-030 scale_in=0, mant_in=0x4000000000000000, sign_in=0 -> result=0x40000000, done 34 edges after start, busy high in between.
REQ-031 Same request with sign_in=1 -> 0xC0000000. Then scale_in=-8 (k=-1), same mantissa, sign_in=0 -> 0x20000000.
REQ-032 scale_in=9 (k=1, e=1), mant_in=0x6000000000000000 -> 0x63000000.
REQ-033 scale_in=0, mant_in=0x4000001800000000 (lsb=1, guard=1, sticky=0) -> 0x40000002. Then scale_in=255 -> 0x7FFFFFFF, and mant_in=0 -> 0x00000000, each with done 2 edges after start.
REQ-034 nar_in=1 -> 0x80000000. Reset pulsed at cycle 10 of a regular request -> outputs 0 and no done. Start held high through DONE_ST -> exactly one done per accepted request.
